// File: rtl/calc2_pkg.sv
// Shared definitions for the calc2 multi-cycle accumulator CPU: instruction
// field positions, opcode and FSM state encodings.
package calc2_pkg;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 29;
  localparam int unsigned SRC_MSB = 28;
  localparam int unsigned SRC_LSB = 27;
  localparam int unsigned DST_MSB = 26;
  localparam int unsigned DST_LSB = 25;
  localparam int unsigned IMM_W   = 25;

  typedef enum logic [2:0] {
    OP_ADDI  = 3'd0,
    OP_SUBI  = 3'd1,
    OP_ANDI  = 3'd2,
    OP_ORI   = 3'd3,
    OP_LOAD  = 3'd4,
    OP_STORE = 3'd5,
    OP_BEQZ  = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/calc2_regfile.sv
// Four-entry register file: two combinational read ports, a debug read port
// and one synchronous write port, all cleared by async reset.
module calc2_regfile
  import calc2_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ra_sel,
  input  logic [1:0]        rb_sel,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  output logic [DATA_W-1:0] dbg,
  input  logic              we,
  input  logic [1:0]        wsel,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign ra  = regs[ra_sel];
  assign rb  = regs[rb_sel];
  assign dbg = regs[dbg_sel];

endmodule

// File: rtl/calc2_core.sv
// calc2 multi-cycle CPU core with a req/ack unified memory port.
// Define CALC2_PERF_EN to build the retired-instruction and active-cycle counters.
module calc2_core
  import calc2_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemAck,
  output logic              Halted,
  output logic [ADDR_W-1:0] Pc,
  input  logic [1:0]        DbgSel,
  output logic [DATA_W-1:0] DbgData,
  output logic [31:0]       InstrCnt,
  output logic [31:0]       CycleCnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  opcode_e                  op_c;
  logic [1:0]               src_c, dst_c;
  logic signed [IMM_W-1:0]  imm_raw_c;
  logic [DATA_W-1:0]        ra_c, rb_c;
  logic                     wb_c, ack_c;

  assign op_c      = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign src_c     = ir_q[SRC_MSB:SRC_LSB];
  assign dst_c     = ir_q[DST_MSB:DST_LSB];
  assign imm_raw_c = ir_q[IMM_W-1:0];
  // Acks that arrive with no request outstanding are ignored.
  assign ack_c     = MemAck & mem_req_q;

  calc2_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (Clk),
    .rst     (Reset),
    .ra_sel  (src_c),
    .rb_sel  (dst_c),
    .dbg_sel (DbgSel),
    .ra      (ra_c),
    .rb      (rb_c),
    .dbg     (DbgData),
    .we      (wb_c),
    .wsel    (dst_c),
    .wdata   (res_q)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    res_d   = res_q;
    addr_d  = addr_q;
    wb_c    = 1'b0;

    case (state_q)
      ST_IDLE: if (Start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (ack_c) begin
          ir_d    = 32'(MemRData);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = ra_c;
        b_d     = rb_c;
        imm_d   = DATA_W'(imm_raw_c);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_c)
          OP_ADDI: begin res_d = a_q + imm_q; state_d = ST_WB; end
          OP_SUBI: begin res_d = a_q - imm_q; state_d = ST_WB; end
          OP_ANDI: begin res_d = a_q & imm_q; state_d = ST_WB; end
          OP_ORI:  begin res_d = a_q | imm_q; state_d = ST_WB; end
          OP_LOAD, OP_STORE: begin
            addr_d  = ADDR_W'(a_q + imm_q);
            state_d = ST_MEM;
          end
          OP_BEQZ: begin
            pc_d    = (a_q == '0) ? pc_q + ADDR_W'(1) + ADDR_W'(imm_q)
                                  : pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (ack_c) begin
          if (op_c == OP_LOAD) begin
            res_d   = MemRData;
            state_d = ST_WB;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        wb_c    = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered and
    // already valid in the first cycle of FETCH/MEM, held until the ack.
    mem_req_d   = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d    = (state_d == ST_MEM) && (op_c == OP_STORE);
    mem_addr_d  = (state_d == ST_FETCH) ? pc_d :
                  (state_d == ST_MEM)   ? addr_d : '0;
    mem_wdata_d = mem_we_d ? b_q : '0;
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      res_q       <= res_d;
      addr_q      <= addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
    end
  end

  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign Halted   = halted_q;
  assign Pc       = pc_q;

`ifdef CALC2_PERF_EN
  logic [31:0] icnt_q, ccnt_q;
  logic        retire_c, active_c;

  // An instruction retires on its last working cycle; HALT counts on entry.
  assign retire_c = (state_q == ST_WB) ||
                    ((state_q == ST_MEM) && ack_c && (op_c == OP_STORE)) ||
                    ((state_q == ST_EXEC) && ((op_c == OP_BEQZ) || (op_c == OP_HALT)));
  assign active_c = state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (retire_c) icnt_q <= icnt_q + 32'd1;
      if (active_c) ccnt_q <= ccnt_q + 32'd1;
    end
  end

  assign InstrCnt = icnt_q;
  assign CycleCnt = ccnt_q;
`else
  assign InstrCnt = '0;
  assign CycleCnt = '0;
`endif

endmodule

// File: tb/tb_calc2_core.sv
// Directed bench for calc2_core: table of small programs run against a
// req/ack memory model with configurable wait states, plus corner sequences.
module tb_calc2_core;

`ifdef CALC2_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] HALT_I = 32'hE000_0000;

  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, MemAck = 1'b0;
  logic        MemReq, MemWe, Halted;
  logic [15:0] MemAddr, Pc;
  logic [31:0] MemWData, MemRData = '0, DbgData, InstrCnt, CycleCnt;
  logic [1:0]  DbgSel = 2'd0;

  calc2_core #(.DATA_W(32), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Halted(Halted), .Pc(Pc),
    .DbgSel(DbgSel), .DbgData(DbgData), .InstrCnt(InstrCnt), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [256];
  int          ack_delay = 0, wait_cnt = 0, cur_len = 0, last_len = 0, unstable = 0, w_cnt = 0;
  logic        hold_en = 1'b0;
  logic [15:0] hold_addr = '0, cap_addr = '0, w_addr = '0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_wdata = '0, w_data = '0;
  int          n_tests = 0, n_fail = 0;

  // Memory model: acks after ack_delay wait cycles and checks that the request
  // stays stable from assertion until it is acked.
  always @(negedge Clk) begin
    if (MemReq) begin
      if (cur_len == 0) begin
        cap_addr = MemAddr; cap_we = MemWe; cap_wdata = MemWData;
      end else if (cap_addr !== MemAddr || cap_we !== MemWe || cap_wdata !== MemWData) begin
        unstable++;
      end
      cur_len++;
      if (!(hold_en && !MemWe && MemAddr == hold_addr) && wait_cnt >= ack_delay) begin
        MemAck   = 1'b1;
        MemRData = mem[MemAddr[7:0]];
        if (MemWe) begin
          mem[MemAddr[7:0]] = MemWData;
          w_cnt++; w_addr = MemAddr; w_data = MemWData;
        end
        last_len = cur_len;
        cur_len  = 0;
        wait_cnt = 0;
      end else begin
        MemAck = 1'b0;
        wait_cnt++;
      end
    end else begin
      MemAck   = 1'b0;
      wait_cnt = 0;
      cur_len  = 0;
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] s,
                                      input logic [1:0] d, input logic [24:0] imm);
    return {op, s, d, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [4:0][31:0] p, input logic [31:0] pre);
    for (int i = 0; i < 256; i++) mem[i] = HALT_I;
    for (int i = 0; i < 5; i++) mem[i] = p[i];
    mem[32] = pre;
  endtask

  task automatic reset_start(input int dly);
    @(negedge Clk) Reset = 1'b1;
    ack_delay = dly; w_cnt = 0; last_len = 0; unstable = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int c = 0;
    while (!Halted && c < 3000) begin
      @(negedge Clk);
      c++;
    end
    chk({nm, "_halted"}, 32'(Halted), 32'd1);
  endtask

  typedef struct {
    string            name;
    logic [4:0][31:0] prog;
    int               dly;
    logic [31:0]      pre;
    logic [1:0]       sel;
    logic [31:0]      exp_reg;
    logic [15:0]      exp_pc;
    logic [31:0]      exp_icnt;
    logic [31:0]      exp_cyc;   // 0 = not checked
    bit               store;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [31:0] i0, i1, i2, i3, i4,
                              input int dly, input logic [31:0] pre, input logic [1:0] sel,
                              input logic [31:0] er, input logic [15:0] epc,
                              input logic [31:0] eic, input logic [31:0] ecyc, input bit st);
    vec_t v;
    v.name = nm; v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3; v.prog[4] = i4;
    v.dly = dly; v.pre = pre; v.sel = sel; v.exp_reg = er; v.exp_pc = epc;
    v.exp_icnt = eic; v.exp_cyc = ecyc; v.store = st;
    return v;
  endfunction

  vec_t vt [12];
  int   viol;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk("addi_halt", enc(0,0,1,25'd5), HALT_I, HALT_I, HALT_I, HALT_I,
                0, 0, 1, 32'd5, 16'd1, 32'd2, 32'd7, 0);
    vt[1]  = mk("addi_wait3", enc(0,0,1,25'd5), HALT_I, HALT_I, HALT_I, HALT_I,
                3, 0, 1, 32'd5, 16'd1, 32'd2, 32'd13, 0);
    vt[2]  = mk("subi_wrap", enc(1,0,3,25'd1), HALT_I, HALT_I, HALT_I, HALT_I,
                0, 0, 3, 32'hFFFF_FFFF, 16'd1, 32'd2, 32'd7, 0);
    vt[3]  = mk("andi", enc(1,0,3,25'd1), enc(2,3,3,25'h0F0), HALT_I, HALT_I, HALT_I,
                0, 0, 3, 32'h0000_00F0, 16'd2, 32'd3, 32'd11, 0);
    vt[4]  = mk("store_load", enc(0,0,1,25'd5), enc(5,0,1,25'h10), enc(4,0,2,25'h10), HALT_I, HALT_I,
                1, 0, 2, 32'd5, 16'd3, 32'd4, 32'd0, 1);
    vt[5]  = mk("load_wait2", enc(4,0,3,25'h20), HALT_I, HALT_I, HALT_I, HALT_I,
                2, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 16'd1, 32'd2, 32'd0, 0);
    vt[6]  = mk("beqz_taken", enc(6,0,0,25'd2), HALT_I, HALT_I, HALT_I, HALT_I,
                0, 0, 0, 32'd0, 16'd3, 32'd2, 32'd0, 0);
    vt[7]  = mk("beqz_not", enc(0,0,1,25'd5), enc(0,0,2,25'd1), enc(0,2,2,25'd1), enc(6,1,0,25'd7), HALT_I,
                0, 0, 2, 32'd2, 16'd4, 32'd5, 32'd0, 0);
    vt[8]  = mk("dst_eq_src", enc(0,0,1,25'd3), enc(0,1,1,25'd4), HALT_I, HALT_I, HALT_I,
                1, 0, 1, 32'd7, 16'd2, 32'd3, 32'd0, 0);
    vt[9]  = mk("ori", enc(3,0,2,25'h123), enc(3,2,2,25'h010), HALT_I, HALT_I, HALT_I,
                0, 0, 2, 32'h0000_0133, 16'd2, 32'd3, 32'd0, 0);
    vt[10] = mk("sx_neg", enc(0,0,1,25'h100_0000), HALT_I, HALT_I, HALT_I, HALT_I,
                0, 0, 1, 32'hFF00_0000, 16'd1, 32'd2, 32'd0, 0);
    vt[11] = mk("sx_pos", enc(0,0,1,25'h0FF_FFFF), enc(1,1,1,25'h1FF_FFFF), HALT_I, HALT_I, HALT_I,
                0, 0, 1, 32'h0100_0000, 16'd2, 32'd3, 32'd0, 0);

    // Reset state.
    repeat (2) @(negedge Clk);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_pc", 32'(Pc), 32'd0);
    chk("rst_icnt", InstrCnt, 32'd0);
    chk("rst_ccnt", CycleCnt, 32'd0);
    for (int s = 0; s < 4; s++) begin
      DbgSel = 2'(s);
      #1 chk($sformatf("rst_r%0d", s), DbgData, 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      load_prog(vt[i].prog, vt[i].pre);
      reset_start(vt[i].dly);
      wait_halt(vt[i].name);
      DbgSel = vt[i].sel;
      #1;
      chk({vt[i].name, "_reg"}, DbgData, vt[i].exp_reg);
      chk({vt[i].name, "_pc"}, 32'(Pc), 32'(vt[i].exp_pc));
      chk({vt[i].name, "_reqlen"}, 32'(last_len), 32'(vt[i].dly + 1));
      chk({vt[i].name, "_stable"}, 32'(unstable), 32'd0);
      chk({vt[i].name, "_icnt"}, InstrCnt, PERF ? vt[i].exp_icnt : 32'd0);
      if (vt[i].exp_cyc != 0)
        chk({vt[i].name, "_ccnt"}, CycleCnt, PERF ? vt[i].exp_cyc : 32'd0);
      chk({vt[i].name, "_wcnt"}, 32'(w_cnt), 32'(vt[i].store));
      if (vt[i].store) begin
        chk({vt[i].name, "_waddr"}, 32'(w_addr), 32'h10);
        chk({vt[i].name, "_wdata"}, w_data, 32'd5);
      end
    end

    // Start is ignored once halted.
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    repeat (10) @(negedge Clk);
    chk("halt_sticky", 32'(Halted), 32'd1);
    chk("halt_pc", 32'(Pc), 32'd2);
    chk("halt_noreq", 32'(MemReq), 32'd0);

    // BEQZ R0,-1 at PC=3 spins forever on PC=3.
    load_prog({HALT_I, enc(6,0,0,25'h1FF_FFFF), enc(0,0,2,25'd9), enc(0,1,1,25'd0), enc(0,0,1,25'd5)}, 0);
    reset_start(0);
    repeat (60) @(negedge Clk);
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      if (Pc !== 16'd3 || Halted !== 1'b0 || (MemReq && MemAddr !== 16'd3)) viol++;
      @(negedge Clk);
    end
    chk("loop_viol", 32'(viol), 32'd0);
    DbgSel = 2'd2;
    #1 chk("loop_r2", DbgData, 32'd9);

    // Reset while a fetch at PC=2 is waiting for an ack.
    load_prog({HALT_I, HALT_I, HALT_I, enc(0,0,2,25'd6), enc(0,0,1,25'd5)}, 0);
    hold_en = 1'b1; hold_addr = 16'd2;
    reset_start(0);
    for (int c = 0; c < 200 && !(MemReq && MemAddr == 16'd2); c++) @(negedge Clk);
    repeat (3) @(negedge Clk);
    chk("stall_req", 32'(MemReq), 32'd1);
    chk("stall_addr", 32'(MemAddr), 32'd2);
    DbgSel = 2'd2;
    #1 chk("stall_r2", DbgData, 32'd6);
    Reset = 1'b1;
    #1;
    chk("midrst_req", 32'(MemReq), 32'd0);
    chk("midrst_pc", 32'(Pc), 32'd0);
    chk("midrst_icnt", InstrCnt, 32'd0);
    for (int s = 0; s < 4; s++) begin
      DbgSel = 2'(s);
      #1 chk($sformatf("midrst_r%0d", s), DbgData, 32'd0);
    end
    hold_en = 1'b0;
    @(negedge Clk) Reset = 1'b0;
    repeat (10) @(negedge Clk);
    chk("idle_noreq", 32'(MemReq), 32'd0);
    chk("idle_pc", 32'(Pc), 32'd0);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    wait_halt("restart");
    chk("restart_pc", 32'(Pc), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
